mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 19 +
 rtl/mem_arbiter_rr_picker.sv | 18 +
 rtl/mem_arbiter.sv | 153 +++++++++++++++
 tb/tb_mem_arbiter.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-requester (dcache/icache) memory arbiter.
package mem_arbiter_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 256;

    // Requester indices; also the bit positions inside grant vectors.
    localparam int DCACHE = 0;
    localparam int ICACHE = 1;

    localparam int WAIT_W = 7;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RELEASE = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_arbiter_rr_picker.sv
// Two-request round-robin selector; ptr names the requester favoured on a tie.
module rr_picker (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = ptr ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates dcache (m0) and icache (m1) line requests onto one Data_Memory port.
//
//   state   | meaning
//   IDLE    | no owner; arbitrate and capture the winner's request
//   BUSY    | request on the memory port, waiting for mem_ack_i or timeout
//   RELEASE | one dead cycle, port idle, requests ignored
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = 64
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic              m0_enable_i,
    input  logic              m0_write_i,
    input  logic [ADDR_W-1:0] m0_addr_i,
    input  logic [DATA_W-1:0] m0_data_i,
    output logic              m0_ack_o,
    output logic [DATA_W-1:0] m0_data_o,

    input  logic              m1_enable_i,
    input  logic              m1_write_i,
    input  logic [ADDR_W-1:0] m1_addr_i,
    input  logic [DATA_W-1:0] m1_data_i,
    output logic              m1_ack_o,
    output logic [DATA_W-1:0] m1_data_o,

    output logic              mem_enable_o,
    output logic              mem_write_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_data_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_data_i,

    output logic [1:0]        grant_o,
    output logic              err_o
);

    arb_state_t        state;
    arb_state_t        state_next;
    logic [1:0]        req;
    logic [1:0]        pick;
    logic [1:0]        grant;
    logic              ptr;
    logic [WAIT_W-1:0] wait_cnt;
    logic              timeout_hit;
    logic              done;

    assign req = {m1_enable_i, m0_enable_i};

    rr_picker u_picker (
        .req   (req),
        .ptr   (ptr),
        .grant (pick)
    );

    // wait_cnt holds the number of BUSY cycles already finished, so the
    // TIMEOUT-th BUSY cycle is the last one allowed to see an ack.
    assign timeout_hit = (wait_cnt == WAIT_W'(TIMEOUT - 1));
    assign done        = (state == BUSY) && (mem_ack_i || timeout_hit);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        mem_enable_o = 1'b0;
        m0_ack_o     = 1'b0;
        m1_ack_o     = 1'b0;
        err_o        = 1'b0;
        case (state)
            IDLE: begin
                if (|req) begin
                    state_next = BUSY;
                end
            end
            BUSY: begin
                mem_enable_o = 1'b1;
                if (mem_ack_i) begin
                    m0_ack_o   = grant[DCACHE];
                    m1_ack_o   = grant[ICACHE];
                    state_next = RELEASE;
                end else if (timeout_hit) begin
                    err_o      = 1'b1;
                    state_next = RELEASE;
                end
            end
            RELEASE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            grant       <= 2'b00;
            ptr         <= 1'b0;
            wait_cnt    <= '0;
            mem_write_o <= 1'b0;
            mem_addr_o  <= '0;
            mem_data_o  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        grant    <= pick;
                        wait_cnt <= '0;
                        if (pick[ICACHE]) begin
                            mem_write_o <= m1_write_i;
                            mem_addr_o  <= m1_addr_i;
                            mem_data_o  <= m1_data_i;
                        end else begin
                            mem_write_o <= m0_write_i;
                            mem_addr_o  <= m0_addr_i;
                            mem_data_o  <= m0_data_i;
                        end
                    end
                end
                BUSY: begin
                    wait_cnt <= wait_cnt + 1'b1;
                    if (done) begin
                        grant <= 2'b00;
                        // Favour whoever was not just served.
                        ptr   <= grant[DCACHE];
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign grant_o   = grant;
    assign m0_data_o = mem_data_i;
    assign m1_data_o = mem_data_i;

    a_single_ack: assert property (@(posedge clk_i) disable iff (rst_i)
        !(m0_ack_o && m1_ack_o));
    a_grant_onehot: assert property (@(posedge clk_i) disable iff (rst_i)
        $onehot0(grant));

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: request rounds drive a queue of expected
// transactions derived from round-robin order and a reference line memory.
module tb_mem_arbiter;

    localparam int AW     = 32;
    localparam int DW     = 256;
    localparam int TO     = 64;
    localparam int NLINES = 64;

    logic          clk = 1'b0;
    logic          rst_i;
    logic          m0_enable_i, m0_write_i, m1_enable_i, m1_write_i;
    logic [AW-1:0] m0_addr_i, m1_addr_i;
    logic [DW-1:0] m0_data_i, m1_data_i;
    logic          m0_ack_o, m1_ack_o;
    logic [DW-1:0] m0_data_o, m1_data_o;
    logic          mem_enable_o, mem_write_o, mem_ack_i;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_data_o, mem_data_i;
    logic [1:0]    grant_o;
    logic          err_o;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .m0_enable_i(m0_enable_i), .m0_write_i(m0_write_i), .m0_addr_i(m0_addr_i),
        .m0_data_i(m0_data_i), .m0_ack_o(m0_ack_o), .m0_data_o(m0_data_o),
        .m1_enable_i(m1_enable_i), .m1_write_i(m1_write_i), .m1_addr_i(m1_addr_i),
        .m1_data_i(m1_data_i), .m1_ack_o(m1_ack_o), .m1_data_o(m1_data_o),
        .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o), .mem_addr_o(mem_addr_o),
        .mem_data_o(mem_data_o), .mem_ack_i(mem_ack_i), .mem_data_i(mem_data_i),
        .grant_o(grant_o), .err_o(err_o)
    );

    // k = BUSY cycle on which memory acks (1..TO), 0 = memory never acks.
    typedef struct {
        int            idx;
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
        int            k;
    } exp_t;

    typedef struct {
        bit            r0, r1, w0, w1, drop0, drop1;
        logic [AW-1:0] a0, a1;
        logic [DW-1:0] d0, d1;
        int            k0, k1;
    } round_t;

    exp_t          sb_q[$];
    int            lat_q[$];
    logic [DW-1:0] mem_env[NLINES];
    logic [DW-1:0] ref_mem[NLINES];
    int            last_served;
    int            n_chk = 0;
    int            n_fail = 0;
    int            busy_cyc;
    bit            mon_on, resp_on, manual_ack, release_expect, done0, done1;

    localparam logic [DW-1:0] LINE1 =
        256'h8888_9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF_1111_2222_3333_4444_5555_6666_7777_0000;
    localparam logic [DW-1:0] LINE2 = {16{16'hECFA}};
    localparam logic [DW-1:0] WPAT  = {4{64'h0123_4567_89AB_CDEF}};

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] rand_line();
        logic [DW-1:0] v;
        for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic int line_of(input logic [AW-1:0] a);
        return int'(a[10:5]);
    endfunction

    function automatic logic [AW-1:0] rand_addr();
        return {21'b0, 6'($urandom_range(0, NLINES - 1)), 5'b0};
    endfunction

    function automatic int pick_k();
        int v;
        v = $urandom_range(0, 9);
        if (v == 0) return 0;
        if (v == 1) return TO;
        if (v == 2) return TO - 1;
        return $urandom_range(1, 12);
    endfunction

    function automatic round_t rnd(input bit r0, input bit w0, input logic [AW-1:0] a0, input int k0,
                                   input bit r1, input bit w1, input logic [AW-1:0] a1, input int k1);
        round_t r;
        r.r0 = r0; r.w0 = w0; r.a0 = a0; r.k0 = k0; r.d0 = rand_line(); r.drop0 = 1'b0;
        r.r1 = r1; r.w1 = w1; r.a1 = a1; r.k1 = k1; r.d1 = rand_line(); r.drop1 = 1'b0;
        return r;
    endfunction

    // Memory model: acks on BUSY cycle k of each transaction, commits writes on ack.
    initial begin : responder
        int k, cyc;
        bit in_txn;
        in_txn = 0; k = 0; cyc = 0;
        mem_ack_i = 1'b0;
        mem_data_i = '0;
        forever begin
            @(posedge clk);
            #2;
            mem_ack_i  = 1'b0;
            mem_data_i = rand_line();
            if (!resp_on) begin
                in_txn    = 0;
                mem_ack_i = manual_ack;
            end else if (mem_enable_o) begin
                if (!in_txn) begin
                    in_txn = 1;
                    cyc    = 1;
                    k      = (lat_q.size() > 0) ? lat_q.pop_front() : 0;
                end else begin
                    cyc++;
                end
                if (cyc == k) begin
                    mem_ack_i = 1'b1;
                    if (mem_write_o) mem_env[line_of(mem_addr_o)] = mem_data_o;
                    else             mem_data_i = mem_env[line_of(mem_addr_o)];
                end
            end else begin
                in_txn = 0;
            end
        end
    end

    initial begin : monitor
        exp_t          e;
        logic [2:0]    act_out, exp_out;
        logic [DW-1:0] rd;
        forever begin
            @(negedge clk);
            if (mon_on) begin
                act_out = {err_o, m1_ack_o, m0_ack_o};
                if (release_expect) begin
                    release_expect = 0;
                    chk("release_enable", mem_enable_o, 0);
                    chk("release_grant", grant_o, 0);
                    chk("release_quiet", act_out, 0);
                end else if (!mem_enable_o) begin
                    chk("idle_quiet", {grant_o, act_out}, 0);
                end else if (sb_q.size() == 0) begin
                    chk("unexpected_busy", mem_enable_o, 0);
                end else begin
                    e = sb_q[0];
                    busy_cyc++;
                    chk("grant", grant_o, (e.idx == 1) ? 2'b10 : 2'b01);
                    chk("mem_write", mem_write_o, e.wr);
                    chk("mem_addr", mem_addr_o, e.addr);
                    if (e.wr) chk("mem_wdata", mem_data_o, e.wdata);
                    if (act_out != 3'b000 || busy_cyc >= TO) begin
                        exp_out = (e.k == 0) ? 3'b100 : ((e.idx == 1) ? 3'b010 : 3'b001);
                        chk("outcome", act_out, exp_out);
                        chk("busy_cycles", busy_cyc, (e.k == 0) ? TO : e.k);
                        if (!e.wr && e.k != 0) begin
                            rd = (e.idx == 1) ? m1_data_o : m0_data_o;
                            chk("read_data", rd, e.rdata);
                        end
                        void'(sb_q.pop_front());
                        if (e.idx == 1) done1 = 1; else done0 = 1;
                        busy_cyc       = 0;
                        release_expect = 1;
                    end
                end
            end
        end
    end

    task automatic run_round(input round_t r);
        int   order[$];
        exp_t e;
        int   guard;
        if (r.r0 && r.r1) begin
            order.push_back((last_served == 0) ? 1 : 0);
            order.push_back((last_served == 0) ? 0 : 1);
        end else if (r.r0) begin
            order.push_back(0);
        end else if (r.r1) begin
            order.push_back(1);
        end
        foreach (order[i]) begin
            e.idx   = order[i];
            e.wr    = (e.idx == 1) ? r.w1 : r.w0;
            e.addr  = (e.idx == 1) ? r.a1 : r.a0;
            e.wdata = (e.idx == 1) ? r.d1 : r.d0;
            e.k     = (e.idx == 1) ? r.k1 : r.k0;
            e.rdata = ref_mem[line_of(e.addr)];
            if (e.wr && e.k != 0) ref_mem[line_of(e.addr)] = e.wdata;
            sb_q.push_back(e);
            lat_q.push_back(e.k);
            last_served = e.idx;
        end
        if (order.size() == 0) begin
            repeat (2) tick();
            return;
        end
        done0 = !r.r0;
        done1 = !r.r1;
        tick();
        m0_enable_i = r.r0; m0_write_i = r.w0; m0_addr_i = r.a0; m0_data_i = r.d0;
        m1_enable_i = r.r1; m1_write_i = r.w1; m1_addr_i = r.a1; m1_data_i = r.d1;
        tick();
        chk("accept_latency", mem_enable_o, 1);
        guard = 0;
        while (!(done0 && done1) && guard < 400) begin
            if (done0 || (r.drop0 && mem_enable_o && grant_o[0])) m0_enable_i = 1'b0;
            if (done1 || (r.drop1 && mem_enable_o && grant_o[1])) m1_enable_i = 1'b0;
            // Captured requesters' fields must no longer matter.
            if (mem_enable_o && grant_o[0]) begin
                m0_addr_i = $urandom; m0_data_i = rand_line(); m0_write_i = 1'($urandom);
            end
            if (mem_enable_o && grant_o[1]) begin
                m1_addr_i = $urandom; m1_data_i = rand_line(); m1_write_i = 1'($urandom);
            end
            tick();
            guard++;
        end
        m0_enable_i = 1'b0;
        m1_enable_i = 1'b0;
        if (guard >= 400) begin
            chk("round_completed", done0 && done1, 1);
            sb_q.delete();
            lat_q.delete();
        end
    endtask

    initial begin : watchdog
        #5ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : main
        round_t r;
        rst_i = 1'b1;
        m0_enable_i = 0; m0_write_i = 0; m0_addr_i = '0; m0_data_i = '0;
        m1_enable_i = 0; m1_write_i = 0; m1_addr_i = '0; m1_data_i = '0;
        mon_on = 0; resp_on = 1; manual_ack = 0; release_expect = 0; busy_cyc = 0;
        done0 = 0; done1 = 0;
        last_served = 1;
        for (int i = 0; i < NLINES; i++) begin
            mem_env[i] = rand_line();
            ref_mem[i] = mem_env[i];
        end
        mem_env[1] = LINE1; ref_mem[1] = LINE1;
        mem_env[2] = LINE2; ref_mem[2] = LINE2;

        repeat (3) tick();
        chk("reset_ctrl", {mem_enable_o, mem_write_o, grant_o, err_o, m0_ack_o, m1_ack_o}, 0);
        chk("reset_addr", mem_addr_o, 0);
        chk("reset_data", mem_data_o, 0);
        rst_i  = 1'b0;
        mon_on = 1;
        tick();

        // Simultaneous after reset: m0 write first, then m1 reads the ECFA line.
        run_round(rnd(1, 1, 32'h0000_0400, 5, 1, 0, 32'h0000_0040, 7));
        // m1 just served: m0 must win the tie.
        run_round(rnd(1, 0, rand_addr(), 3, 1, 0, rand_addr(), 4));
        // Single read, latency 10.
        run_round(rnd(1, 0, 32'h0000_0020, 10, 0, 0, 32'h0, 0));
        // m1 times out, pending m0 accepted after RELEASE.
        run_round(rnd(1, 0, rand_addr(), 2, 1, 0, rand_addr(), 0));
        // Write path into line 16.
        r = rnd(1, 1, 32'h0000_0200, 6, 0, 0, 32'h0, 0);
        r.d0 = WPAT;
        run_round(r);
        chk("mem16_written", mem_env[16], WPAT);
        // Ack in the same cycle the timeout would fire.
        run_round(rnd(0, 0, 32'h0, 0, 1, 0, rand_addr(), TO));
        // Requester drops enable while BUSY.
        r = rnd(1, 0, 32'h0000_0020, 5, 0, 0, 32'h0, 0);
        r.drop0 = 1;
        run_round(r);

        // Reset on BUSY cycle 5 (pointer currently favours m1).
        tick();
        mon_on = 0; resp_on = 0;
        m0_enable_i = 1; m0_write_i = 1; m0_addr_i = 32'h0000_0060; m0_data_i = WPAT;
        repeat (5) tick();
        chk("rst_mid_busy_pre", mem_enable_o, 1);
        rst_i = 1'b1;
        tick();
        chk("rst_mid_ctrl", {mem_enable_o, mem_write_o, grant_o, err_o, m0_ack_o, m1_ack_o}, 0);
        chk("rst_mid_addr", mem_addr_o, 0);
        chk("rst_mid_data", mem_data_o, 0);
        rst_i = 1'b0; m0_enable_i = 0; manual_ack = 1;
        @(negedge clk);
        chk("late_ack_ignored", {m0_ack_o, m1_ack_o, err_o, mem_enable_o}, 0);
        tick();
        manual_ack = 0;
        @(negedge clk);
        chk("late_ack_no_busy", {mem_enable_o, grant_o}, 0);
        tick();
        sb_q.delete(); lat_q.delete();
        busy_cyc = 0; release_expect = 0; last_served = 1;
        resp_on = 1; mon_on = 1;
        tick();
        // Pointer back at m0 after reset.
        run_round(rnd(1, 0, rand_addr(), 4, 1, 1, rand_addr(), 3));

        repeat (60) begin
            r = rnd(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rand_addr(), pick_k(),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rand_addr(), pick_k());
            r.drop0 = ($urandom_range(0, 3) == 0);
            r.drop1 = ($urandom_range(0, 3) == 0);
            run_round(r);
            repeat ($urandom_range(0, 2)) tick();
        end
        repeat (3) tick();
        chk("scoreboard_empty", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
